// File: rtl/uart_pkg.sv
// Shared types and constants for the memory-mapped UART transmitter.
package uart_pkg;

  typedef enum logic [1:0] {
    IDLE,
    START,
    DATA,
    STOP
  } tx_state_e;

  // Register select values taken from DataAdr[3:2]
  localparam logic [1:0] REG_TXDATA = 2'd0;
  localparam logic [1:0] REG_STATUS = 2'd1;
  localparam logic [1:0] REG_CTRL   = 2'd2;

  // Bit positions inside the STATUS register
  localparam int STAT_EMPTY = 0;
  localparam int STAT_FULL  = 1;
  localparam int STAT_BUSY  = 2;
  localparam int STAT_OVF   = 3;

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO; a push while full is accepted only if a pop happens the same cycle.
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 8
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     push,
  input  logic                     pop,
  input  logic [WIDTH-1:0]         din,
  output logic [WIDTH-1:0]         dout,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] mem_d [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [AW:0]      count_q, count_d;
  logic             do_push, do_pop;

  assign full    = (count_q == (AW+1)'(DEPTH));
  assign empty   = (count_q == '0);
  assign count   = count_q;
  assign dout    = mem_q[rd_ptr_q];
  assign do_pop  = pop & ~empty;
  assign do_push = push & (~full | do_pop);

  // Next-state for storage, pointers (wrapping at DEPTH) and occupancy
  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (do_push) begin
      mem_d[wr_ptr_q] = din;
      wr_ptr_d        = wr_ptr_q + AW'(1);
    end
    if (do_pop) begin
      rd_ptr_d = rd_ptr_q + AW'(1);
    end
    case ({do_push, do_pop})
      2'b10:   count_d = count_q + (AW+1)'(1);
      2'b01:   count_d = count_q - (AW+1)'(1);
      default: count_d = count_q;
    endcase
  end

  // Register FIFO state; reset discards all contents
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

endmodule

// File: rtl/mmio_uart_tx.sv
// CPU-mapped UART transmitter: register window, TX FIFO and 8N1 serializer.
module mmio_uart_tx
  import uart_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR    = 32'h0000_1000,
  parameter int          CLKS_PER_BIT = 434,
  parameter int          FIFO_DEPTH   = 8
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        MemWrite,
  input  logic [31:0] DataAdr,
  input  logic [31:0] WriteData,
  output logic [31:0] ReadData,
  output logic        Hit,
  output logic        tx,
  output logic        irq
);

  localparam int BCW = $clog2(CLKS_PER_BIT);
  localparam logic [BCW-1:0] BC_LAST = BCW'(CLKS_PER_BIT - 1);

  tx_state_e state_q, state_d;
  logic [BCW-1:0] bc_q, bc_d;
  logic [2:0]     bit_idx_q, bit_idx_d;
  logic [7:0]     sh_q, sh_d;
  logic           tx_q, tx_d;
  logic           en_q, en_d;
  logic           ovf_q, ovf_d;

  logic [1:0]     sel;
  logic           wr, push, pop, busy, start_ok, bc_last;
  logic [7:0]     fifo_dout;
  logic           fifo_full, fifo_empty;
  logic [$clog2(FIFO_DEPTH):0] fifo_count;
  logic           unused_bits;

  assign sel      = DataAdr[3:2];
  assign Hit      = (DataAdr[31:4] == BASE_ADDR[31:4]);
  assign wr       = MemWrite & Hit;
  assign push     = wr & (sel == REG_TXDATA);
  assign busy     = (state_q != IDLE) | ~fifo_empty;
  assign start_ok = en_q & ~fifo_empty;
  assign bc_last  = (bc_q == BC_LAST);
  assign tx       = tx_q;
  assign irq      = ovf_q;

  assign unused_bits = ^{WriteData[31:8], DataAdr[1:0], fifo_count};

  sync_fifo #(
    .WIDTH (8),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (push),
    .pop   (pop),
    .din   (WriteData[7:0]),
    .dout  (fifo_dout),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (fifo_count)
  );

  // Control/status updates; a dropped push outranks a same-cycle overflow clear
  always_comb begin
    en_d  = en_q;
    ovf_d = ovf_q;
    if (wr && (sel == REG_CTRL)) en_d = WriteData[0];
    if (wr && (sel == REG_STATUS) && WriteData[3]) ovf_d = 1'b0;
    if (push && fifo_full && !pop) ovf_d = 1'b1;
  end

  // Serializer: start bit, 8 data bits LSB first, stop bit; chains frames with no gap
  always_comb begin
    state_d   = state_q;
    bc_d      = bc_q;
    bit_idx_d = bit_idx_q;
    sh_d      = sh_q;
    tx_d      = tx_q;
    pop       = 1'b0;
    case (state_q)
      IDLE: begin
        bc_d = '0;
        tx_d = 1'b1;
        if (start_ok) begin
          pop     = 1'b1;
          sh_d    = fifo_dout;
          tx_d    = 1'b0;
          state_d = START;
        end
      end
      START: begin
        if (bc_last) begin
          bc_d      = '0;
          bit_idx_d = 3'd0;
          tx_d      = sh_q[0];
          state_d   = DATA;
        end else begin
          bc_d = bc_q + BCW'(1);
        end
      end
      DATA: begin
        if (bc_last) begin
          bc_d = '0;
          if (bit_idx_q == 3'd7) begin
            tx_d    = 1'b1;
            state_d = STOP;
          end else begin
            bit_idx_d = bit_idx_q + 3'd1;
            tx_d      = sh_q[1];
            sh_d      = {1'b0, sh_q[7:1]};
          end
        end else begin
          bc_d = bc_q + BCW'(1);
        end
      end
      STOP: begin
        if (bc_last) begin
          bc_d = '0;
          if (start_ok) begin
            pop     = 1'b1;
            sh_d    = fifo_dout;
            tx_d    = 1'b0;
            state_d = START;
          end else begin
            state_d = IDLE;
          end
        end else begin
          bc_d = bc_q + BCW'(1);
        end
      end
      default: begin
        state_d = IDLE;
        tx_d    = 1'b1;
      end
    endcase
  end

  // State registers; reset forces the line idle high immediately
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= IDLE;
      bc_q      <= '0;
      bit_idx_q <= 3'd0;
      sh_q      <= 8'd0;
      tx_q      <= 1'b1;
      en_q      <= 1'b1;
      ovf_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      bc_q      <= bc_d;
      bit_idx_q <= bit_idx_d;
      sh_q      <= sh_d;
      tx_q      <= tx_d;
      en_q      <= en_d;
      ovf_q     <= ovf_d;
    end
  end

  // Register read mux; anything outside the window reads as zero
  always_comb begin
    ReadData = 32'd0;
    if (Hit) begin
      case (sel)
        REG_STATUS: begin
          ReadData[STAT_EMPTY] = fifo_empty;
          ReadData[STAT_FULL]  = fifo_full;
          ReadData[STAT_BUSY]  = busy;
          ReadData[STAT_OVF]   = ovf_q;
        end
        REG_CTRL: ReadData[0] = en_q;
        default:  ReadData = 32'd0;
      endcase
    end
  end

endmodule

// File: tb/tb_mmio_uart_tx.sv
// Self-checking bench for mmio_uart_tx with a frame-level reference model.
module tb_mmio_uart_tx;

  localparam logic [31:0] BASE  = 32'h0000_1000;
  localparam int          CPB   = 4;
  localparam int          DEPTH = 4;
  localparam int          FRAME = 10 * CPB;

  logic        clk = 1'b0;
  logic        reset;
  logic        MemWrite;
  logic [31:0] DataAdr;
  logic [31:0] WriteData;
  logic [31:0] ReadData;
  logic        Hit;
  logic        tx;
  logic        irq;

  int n_cmp = 0;
  int n_bad = 0;

  logic [7:0] s_bytes [8];
  int         s_at    [8];

  always #5 clk = ~clk;

  mmio_uart_tx #(
    .BASE_ADDR    (BASE),
    .CLKS_PER_BIT (CPB),
    .FIFO_DEPTH   (DEPTH)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .MemWrite  (MemWrite),
    .DataAdr   (DataAdr),
    .WriteData (WriteData),
    .ReadData  (ReadData),
    .Hit       (Hit),
    .tx        (tx),
    .irq       (irq)
  );

  // Hold reset across two edges and release it between edges
  task automatic do_reset();
    reset     = 1'b1;
    MemWrite  = 1'b0;
    DataAdr   = 32'd0;
    WriteData = 32'd0;
    repeat (2) @(posedge clk);
    #2 reset = 1'b0;
    @(posedge clk);
    #1;
  endtask

  // One CPU store landing on the next rising edge
  task automatic do_store(input logic [31:0] a, input logic [31:0] d);
    MemWrite  = 1'b1;
    DataAdr   = a;
    WriteData = d;
    @(posedge clk);
    #1;
    MemWrite  = 1'b0;
    DataAdr   = BASE + 32'h4;
  endtask

  // Drives pushes (or an enable write when kick=1) and checks tx and STATUS every cycle
  // against a frame-level model: frame f starts on edge 1+40f, bytes arrive per s_at.
  task automatic run_stream(input int n, input bit kick, input logic ovf_e);
    int pushes, pops, cnt, t, f, b;
    logic exp_tx, busy_e;
    logic [31:0] exp_st;
    for (int c = 0; c <= n * FRAME + 1; c++) begin
      MemWrite = 1'b0;
      if (kick) begin
        if (c == 0) begin
          MemWrite  = 1'b1;
          DataAdr   = BASE + 32'h8;
          WriteData = 32'h1;
        end
      end else begin
        for (int k = 0; k < n; k++) begin
          if (s_at[k] == c) begin
            MemWrite       = 1'b1;
            DataAdr        = BASE | 32'($urandom_range(0, 3));
            WriteData      = $urandom;
            WriteData[7:0] = s_bytes[k];
          end
        end
      end
      @(posedge clk);
      #1;
      MemWrite = 1'b0;
      DataAdr  = BASE + 32'h4;
      #1;
      if (kick) pushes = n;
      else begin
        pushes = 0;
        for (int k = 0; k < n; k++) if (s_at[k] <= c) pushes++;
      end
      pops = (c >= 1) ? ((c - 1) / FRAME + 1) : 0;
      if (pops > n) pops = n;
      cnt = pushes - pops;
      if (c == 0 || c > n * FRAME) exp_tx = 1'b1;
      else begin
        t = c - 1;
        f = t / FRAME;
        b = (t % FRAME) / CPB;
        if (b == 0) exp_tx = 1'b0;
        else if (b == 9) exp_tx = 1'b1;
        else exp_tx = s_bytes[f][b-1];
      end
      busy_e = ((c >= 1) && (c <= n * FRAME)) || (cnt != 0);
      exp_st = {28'd0, ovf_e, busy_e, (cnt == DEPTH), (cnt == 0)};
      n_cmp++;
      if (tx !== exp_tx) begin
        n_bad++;
        $display("[TB] FAIL stream_tx cycle=%0d got=%b want=%b", c, tx, exp_tx);
      end
      n_cmp++;
      if (ReadData !== exp_st) begin
        n_bad++;
        $display("[TB] FAIL stream_status cycle=%0d got=%h want=%h", c, ReadData, exp_st);
      end
    end
  endtask

  // Reset values, decode, reserved and non-hit accesses
  task automatic test_reset();
    do_reset();
    DataAdr = 32'h0;
    #1;
    n_cmp++; if (Hit !== 1'b0) begin n_bad++; $display("[TB] FAIL reset_hit0 got=%b want=0", Hit); end
    n_cmp++; if (ReadData !== 32'd0) begin n_bad++; $display("[TB] FAIL reset_rd0 got=%h want=0", ReadData); end
    n_cmp++; if (tx !== 1'b1) begin n_bad++; $display("[TB] FAIL reset_tx got=%b want=1", tx); end
    n_cmp++; if (irq !== 1'b0) begin n_bad++; $display("[TB] FAIL reset_irq got=%b want=0", irq); end
    DataAdr = BASE + 32'h4;
    #1;
    n_cmp++; if (Hit !== 1'b1) begin n_bad++; $display("[TB] FAIL reset_hit got=%b want=1", Hit); end
    n_cmp++; if (ReadData !== 32'h1) begin n_bad++; $display("[TB] FAIL reset_status got=%h want=1", ReadData); end
    DataAdr = BASE + 32'h8;
    #1;
    n_cmp++; if (ReadData !== 32'h1) begin n_bad++; $display("[TB] FAIL reset_ctrl got=%h want=1", ReadData); end
    DataAdr = BASE + 32'hC;
    #1;
    n_cmp++; if (ReadData !== 32'h0) begin n_bad++; $display("[TB] FAIL reserved_rd got=%h want=0", ReadData); end
    DataAdr = BASE + 32'h10;
    #1;
    n_cmp++; if (Hit !== 1'b0) begin n_bad++; $display("[TB] FAIL hit_above got=%b want=0", Hit); end
    do_store(32'h0000_2000, 32'h55);
    do_store(BASE + 32'hC, 32'hFF);
    #1;
    n_cmp++; if (ReadData !== 32'h1) begin n_bad++; $display("[TB] FAIL nohit_write got=%h want=1", ReadData); end
    repeat (3) begin @(posedge clk); #1; end
    n_cmp++; if (tx !== 1'b1) begin n_bad++; $display("[TB] FAIL nohit_tx got=%b want=1", tx); end
    do_store(BASE + 32'h8, 32'hFFFF_FFFE);
    DataAdr = BASE + 32'h8;
    #1;
    n_cmp++; if (ReadData !== 32'h0) begin n_bad++; $display("[TB] FAIL ctrl_clear got=%h want=0", ReadData); end
    do_store(BASE + 32'h8, 32'hFFFF_FFFF);
    DataAdr = BASE + 32'h8;
    #1;
    n_cmp++; if (ReadData !== 32'h1) begin n_bad++; $display("[TB] FAIL ctrl_set got=%h want=1", ReadData); end
  endtask

  // One 0xA5 frame with exact bit timing
  task automatic test_single_frame();
    do_reset();
    s_bytes[0] = 8'hA5;
    s_at[0]    = 0;
    run_stream(1, 1'b0, 1'b0);
  endtask

  // Three queued bytes go out as contiguous frames
  task automatic test_back_to_back();
    do_reset();
    s_bytes[0] = 8'h01; s_at[0] = 0;
    s_bytes[1] = 8'h02; s_at[1] = 1;
    s_bytes[2] = 8'h03; s_at[2] = 2;
    run_stream(3, 1'b0, 1'b0);
  endtask

  // Fill while disabled, overflow, clear the flag, then enable and drain
  task automatic test_overflow();
    int bad_idle;
    do_reset();
    do_store(BASE + 32'h8, 32'h0);
    for (int k = 0; k < 6; k++) begin
      s_bytes[k] = 8'($urandom);
      do_store(BASE, {24'($urandom), s_bytes[k]});
      if (k == 3) begin
        #1;
        n_cmp++; if (ReadData !== 32'h6) begin n_bad++; $display("[TB] FAIL ovf_fill got=%h want=6", ReadData); end
      end
    end
    #1;
    n_cmp++; if (ReadData !== 32'hE) begin n_bad++; $display("[TB] FAIL ovf_status got=%h want=e", ReadData); end
    n_cmp++; if (irq !== 1'b1) begin n_bad++; $display("[TB] FAIL ovf_irq got=%b want=1", irq); end
    do_store(BASE + 32'h4, 32'h8);
    #1;
    n_cmp++; if (ReadData !== 32'h6) begin n_bad++; $display("[TB] FAIL ovf_clear got=%h want=6", ReadData); end
    n_cmp++; if (irq !== 1'b0) begin n_bad++; $display("[TB] FAIL ovf_irq_clear got=%b want=0", irq); end
    run_stream(4, 1'b1, 1'b0);
    bad_idle = 0;
    repeat (20) begin
      @(posedge clk); #1;
      if (tx !== 1'b1) bad_idle++;
    end
    n_cmp++; if (bad_idle !== 0) begin n_bad++; $display("[TB] FAIL ovf_extra_frames got=%0d low cycles want=0", bad_idle); end
  endtask

  // Push arrives on the edge the stop bit pops from a full FIFO
  task automatic test_full_push_pop();
    do_reset();
    for (int k = 0; k < 6; k++) s_bytes[k] = 8'($urandom);
    s_at[0] = 0; s_at[1] = 1; s_at[2] = 2; s_at[3] = 3; s_at[4] = 4;
    s_at[5] = 1 + FRAME;
    run_stream(6, 1'b0, 1'b0);
    n_cmp++; if (irq !== 1'b0) begin n_bad++; $display("[TB] FAIL fullpop_irq got=%b want=0", irq); end
  endtask

  // Random bytes, random arrival gaps and random address low bits
  task automatic test_random();
    int n;
    repeat (4) begin
      n = $urandom_range(1, 4);
      s_at[0] = 0;
      for (int k = 0; k < n; k++) begin
        s_bytes[k] = 8'($urandom);
        if (k > 0) s_at[k] = s_at[k-1] + $urandom_range(1, 12);
      end
      run_stream(n, 1'b0, 1'b0);
    end
  endtask

  // Reset in the middle of a data bit with more bytes queued
  task automatic test_reset_mid_frame();
    int bad_idle;
    do_reset();
    do_store(BASE, 32'h00);
    do_store(BASE, 32'hFF);
    do_store(BASE, 32'h0F);
    repeat (10) begin @(posedge clk); #1; end
    n_cmp++; if (tx !== 1'b0) begin n_bad++; $display("[TB] FAIL midframe_pre got=%b want=0", tx); end
    #2 reset = 1'b1;
    #1;
    n_cmp++; if (tx !== 1'b1) begin n_bad++; $display("[TB] FAIL async_reset_tx got=%b want=1", tx); end
    repeat (2) @(posedge clk);
    #2 reset = 1'b0;
    @(posedge clk);
    #1;
    DataAdr = BASE + 32'h4;
    #1;
    n_cmp++; if (ReadData !== 32'h1) begin n_bad++; $display("[TB] FAIL post_reset_status got=%h want=1", ReadData); end
    bad_idle = 0;
    repeat (50) begin
      @(posedge clk); #1;
      if (tx !== 1'b1) bad_idle++;
    end
    n_cmp++; if (bad_idle !== 0) begin n_bad++; $display("[TB] FAIL post_reset_resume got=%0d low cycles want=0", bad_idle); end
  endtask

  initial begin
    reset     = 1'b1;
    MemWrite  = 1'b0;
    DataAdr   = 32'd0;
    WriteData = 32'd0;
    $display("[TB] start");
    test_reset();
    test_single_frame();
    test_back_to_back();
    test_overflow();
    test_full_push_pop();
    test_random();
    test_reset_mid_frame();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
